// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: two-entry skid FIFO toward the memory stage, plus the sticky pipeline halt.
// Optional `EX_MEM_FWD_EN adds the fwd_valid/fwd_reg/fwd_data bypass outputs taken from the head entry.
module ex_mem_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [DATA_WIDTH-1:0]     ex_alu_out,
  input  logic                      ex_sf,
  input  logic                      ex_zf,
  input  logic                      ex_of,
  input  logic                      ex_cf,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wr_reg,
  input  logic                      ex_reg_wr_en,
  input  logic                      ex_mem_rd,
  input  logic                      ex_mem_wr,
  input  logic                      ex_halt,
  input  logic                      flush,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [DATA_WIDTH-1:0]     mem_alu_out,
  output logic [DATA_WIDTH-1:0]     mem_store_data,
  output logic                      mem_sf,
  output logic                      mem_zf,
  output logic                      mem_of,
  output logic                      mem_cf,
  output logic                      mem_reg_wr_en,
  output logic                      mem_mem_rd,
  output logic                      mem_mem_wr,
  output logic                      mem_halt,
  output logic [REG_ADDR_WIDTH-1:0] mem_wr_reg,
  output logic                      halted
`ifdef EX_MEM_FWD_EN
  ,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_reg,
  output logic [DATA_WIDTH-1:0]     fwd_data
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     alu;
    logic                      sf;
    logic                      zf;
    logic                      of;
    logic                      cf;
    logic [DATA_WIDTH-1:0]     store;
    logic [REG_ADDR_WIDTH-1:0] wr_reg;
    logic                      reg_wr_en;
    logic                      mem_rd;
    logic                      mem_wr;
    logic                      halt;
  } entry_t;

  entry_t     head_q, head_d, tail_q, tail_d;
  entry_t     in_e, out_e;
  logic [1:0] count_q, count_d, count_after_pop;
  logic       halted_q, halted_d;
  logic       ex_ready_q, ex_ready_d;
  logic       push, pop;

  assign in_e = {ex_alu_out, ex_sf, ex_zf, ex_of, ex_cf, ex_store_data,
                 ex_wr_reg, ex_reg_wr_en, ex_mem_rd, ex_mem_wr, ex_halt};

  assign mem_valid = (count_q != 2'd0);
  assign push      = ex_valid && ex_ready_q;
  assign pop       = mem_valid && mem_ready;

  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    halted_d        = halted_q;
    count_after_pop = count_q - {1'b0, pop};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        head_d   = tail_q;
        halted_d = halted_q | head_q.halt;
      end
      // A push lands in head whenever the stage is empty after this cycle's pop.
      if (push) begin
        if (count_after_pop == 2'd0) head_d = in_e;
        else                         tail_d = in_e;
      end
      count_d = count_after_pop + {1'b0, push};
    end
    ex_ready_d = (count_d < 2'd2) && !halted_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      halted_q   <= 1'b0;
      ex_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
      ex_ready_q <= ex_ready_d;
    end
  end

  assign out_e = mem_valid ? head_q : '0;

  assign ex_ready       = ex_ready_q;
  assign halted         = halted_q;
  assign mem_alu_out    = out_e.alu;
  assign mem_store_data = out_e.store;
  assign mem_sf         = out_e.sf;
  assign mem_zf         = out_e.zf;
  assign mem_of         = out_e.of;
  assign mem_cf         = out_e.cf;
  assign mem_reg_wr_en  = out_e.reg_wr_en;
  assign mem_mem_rd     = out_e.mem_rd;
  assign mem_mem_wr     = out_e.mem_wr;
  assign mem_halt       = out_e.halt;
  assign mem_wr_reg     = out_e.wr_reg;

`ifdef EX_MEM_FWD_EN
  // Loads are excluded: their data is not known until the memory stage completes.
  assign fwd_valid = mem_valid && out_e.reg_wr_en && !out_e.mem_rd;
  assign fwd_reg   = out_e.wr_reg;
  assign fwd_data  = out_e.alu;
`endif

endmodule
